fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Serial transmit stage directly downstream of the byte FIFO buffer. Pops one byte at a time through the FIFO's read_enable / data_out / empty interface and emits it as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, stop bit(s). Provides a busy flag and a per-frame completion pulse for status and interrupt logic.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
PARITY, 0, 0 = none, 1 = even, 2 = odd; any other value is treated as none.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clock  input  1  system clock; all logic on the rising edge
reset_n  input  1  asynchronous active-low reset
tx_enable  input  1  level; when 1, new frames may start
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO head byte; valid whenever fifo_empty = 0
fifo_read_enable  output  1  one-cycle pop strobe to the FIFO
tx  output  1  serial line; idle high
busy  output  1  1 from the pop cycle until the last stop bit ends
frame_done  output  1  one-cycle pulse at the end of the last stop bit

Behaviour:
- Reset is asynchronous and active-low: the block clears immediately on reset_n = 0, with no clock edge required.
- Reset values: tx = 1, fifo_read_enable = 0, busy = 0, frame_done = 0, state = IDLE, all counters = 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1.
  - fifo_read_enable = (state == IDLE) & tx_enable & ~fifo_empty. This is combinational from state and those two inputs only; there is no combinational path from fifo_data.
  - On the same edge that fifo_read_enable is 1, the shift register captures fifo_data and the state moves to START. The pop and the capture take exactly one cycle.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Bit 0 is sent first. Each bit is held CLKS_PER_BIT cycles.
  - A 3-bit index counts 0..7. After bit 7 the state moves to PARITY if parity is enabled, otherwise to STOP.
- PARITY:
  - Parity bit = XOR of the captured byte (even), or its inverse (odd). It is computed from the captured byte, not from fifo_data.
  - Held CLKS_PER_BIT cycles.
- STOP:
  - tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - frame_done = 1 in the final cycle of STOP, then the state returns to IDLE.
- tx is driven from a register, so the line is glitch-free.
- busy = 1 in the pop cycle and in every cycle of START, DATA, PARITY and STOP.
- Frame timing:
  - Frame length = CLKS_PER_BIT × (10 + P + (STOP_BITS − 1)) cycles after the pop cycle, where P = 1 if parity is enabled, else 0.
  - With back-to-back data there is exactly one IDLE (pop) cycle between frames, so the frame-start period is that length + 1.
- Bit-period counter: width ceil(log2(CLKS_PER_BIT)). It counts 0..CLKS_PER_BIT−1, reloads to 0 on every bit boundary, and wraps with no drift.
- Boundary conditions:
  - tx_enable falls mid-frame: the current frame completes normally and no further pop occurs.
  - fifo_empty changes mid-frame: ignored.
  - FIFO empty in IDLE: no pop; tx stays 1 and busy stays 0.
  - Reset mid-frame: tx returns to 1 immediately. The partially sent byte is discarded and is not re-read from the FIFO.
  - No pop ever occurs outside IDLE, so at most one byte is popped per frame.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2;
  - a function computing the bit-counter width from CLKS_PER_BIT.
- One sub-module: uart_bit_timer.
  - Inputs: clock, reset_n, restart.
  - Output: bit_tick, pulsed on the last cycle of each bit period.
  - Parameter: CLKS_PER_BIT.
- The FSM, shift register and parity logic stay in fifo_uart_tx.

Test Plan:
1. CLKS_PER_BIT = 4, PARITY = 0, FIFO holds 0xA5, tx_enable = 1:
   - fifo_read_enable pulses exactly 1 cycle.
   - tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
   - frame_done pulses in cycle 40 after the pop.
   - busy is high for 41 cycles.
2. PARITY = 1, byte 0x07: parity bit = 1. PARITY = 2, byte 0x07: parity bit = 0. Byte 0x00 with even parity: parity bit = 0. Frame length is 44 cycles.
3. FIFO holds 0x3C then 0xC3, CLKS_PER_BIT = 4:
   - The second pop occurs on the cycle after the first frame_done.
   - Start bits begin 41 cycles apart.
   - Both bytes appear LSB first.
   - fifo_read_enable is asserted exactly twice in total.
4. fifo_empty = 1 for 100 cycles with tx_enable = 1: fifo_read_enable, busy and frame_done stay 0; tx stays 1. Then push 0x55: the pop occurs in the cycle in which fifo_empty first reads 0.
5. tx_enable drops during DATA bit 3 with a second byte pending: the current frame completes with frame_done, then no pop occurs and tx stays 1. Re-asserting tx_enable pops the second byte the next cycle.
6. reset_n asserted asynchronously mid-DATA (between clock edges):
   - tx = 1, busy = 0 and fifo_read_enable = 0 immediately, before the next clock edge.
   - After release with the FIFO non-empty, a pop occurs on the first clock edge and a fresh, complete frame follows.
   - STOP_BITS = 2 variant: the stop phase is 8 cycles at CLKS_PER_BIT = 4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

    // Transmitter frame phases.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Parity selection codes; anything else behaves as PAR_NONE.
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Width of a counter that must reach clks - 1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period timer. Held at zero while restart is high and
// pulses bit_tick on the last clock of every bit period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = (cnt == LAST);

    // Count 0..CLKS_PER_BIT-1 and reload on each boundary so periods never drift.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and serialises them
// as start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_enable,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam bit PAR_EN   = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
    localparam bit PAR_INV  = (PARITY == PAR_ODD);
    localparam bit TWO_STOP = (STOP_BITS == 2);

    tx_state_t  state;
    logic [7:0] data_q;
    logic [2:0] bit_idx;
    logic       stop_cnt;
    logic       tx_q;
    logic       bit_tick;
    logic       timer_restart;
    logic       last_stop;
    logic       par_bit;

    // Pop only from IDLE; gating with reset_n keeps the strobe low during reset
    // even though the state already reads IDLE.
    assign fifo_read_enable = reset_n & (state == ST_IDLE) & tx_enable & ~fifo_empty;
    assign busy             = (state != ST_IDLE) | fifo_read_enable;
    assign timer_restart    = (state == ST_IDLE);
    assign last_stop        = ~TWO_STOP | stop_cnt;
    assign frame_done       = (state == ST_STOP) & bit_tick & last_stop;
    assign par_bit          = (^data_q) ^ PAR_INV;
    assign tx               = tx_q;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (timer_restart),
        .bit_tick(bit_tick)
    );

    // Frame sequencer; tx is loaded one edge ahead so the line comes from a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_read_enable) begin
                        data_q   <= fifo_data;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                        tx_q     <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_q  <= data_q[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PAR_EN) begin
                                tx_q  <= par_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= data_q[bit_idx + 3'd1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx_q  <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (last_stop) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx. Three instances at CLKS_PER_BIT = 4:
// 0 = no parity / 1 stop, 1 = even parity / 1 stop, 2 = odd parity / 2 stops.
module tb_fifo_uart_tx;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] tx_en;

    // Byte FIFO contents per instance and expected frames (bit i = i-th bit on the line).
    logic [7:0]  fifo_q [3][$];
    logic [11:0] exp_q  [3][$];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_ch
        localparam int unsigned Par = (g == 0) ? 0 : ((g == 1) ? 1 : 2);
        localparam int unsigned Stp = (g == 2) ? 2 : 1;
        localparam int Len = 4 * (10 + ((Par != 0) ? 1 : 0) + int'(Stp) - 1);

        logic       fifo_empty = 1'b1;
        logic [7:0] fifo_data  = 8'h00;
        logic       rd, tx, busy, done;
        bit         in_frame = 1'b0;
        bit         pop_pend = 1'b0;
        int         cyc      = 0;
        int         pops     = 0;
        logic [11:0] cur     = '1;
        logic       exp_rd, exp_tx, exp_busy, exp_done;

        fifo_uart_tx #(
            .CLKS_PER_BIT(4),
            .PARITY      (Par),
            .STOP_BITS   (Stp)
        ) u_dut (
            .clock           (clock),
            .reset_n         (reset_n),
            .tx_enable       (tx_en[g]),
            .fifo_empty      (fifo_empty),
            .fifo_data       (fifo_data),
            .fifo_read_enable(rd),
            .tx              (tx),
            .busy            (busy),
            .frame_done      (done)
        );

        // FIFO model updates its outputs at the falling edge; the monitor then
        // samples one time unit later, i.e. the values the next rising edge sees.
        always begin
            @(negedge clock);
            if (pop_pend) begin
                void'(fifo_q[g].pop_front());
                pop_pend = 1'b0;
            end
            fifo_empty = (fifo_q[g].size() == 0);
            fifo_data  = fifo_empty ? 8'h00 : fifo_q[g][0];
            #1;
            if (!reset_n) begin
                in_frame = 1'b0;
                cyc      = 0;
            end else begin
                exp_rd = !in_frame && tx_en[g] && !fifo_empty;
                if (in_frame) begin
                    cyc++;
                    exp_tx   = cur[(cyc - 1) / 4];
                    exp_busy = 1'b1;
                    exp_done = (cyc == Len);
                end else begin
                    exp_tx   = 1'b1;
                    exp_busy = exp_rd;
                    exp_done = 1'b0;
                end
                check($sformatf("i%0d c%0d read_enable", g, cyc), rd, exp_rd);
                check($sformatf("i%0d c%0d tx", g, cyc), tx, exp_tx);
                check($sformatf("i%0d c%0d busy", g, cyc), busy, exp_busy);
                check($sformatf("i%0d c%0d frame_done", g, cyc), done, exp_done);
                if (in_frame && cyc == Len) in_frame = 1'b0;
                if (rd) begin
                    pop_pend = 1'b1;
                    pops++;
                    check($sformatf("i%0d pop with frame queued", g), exp_q[g].size() != 0, 1);
                    if (exp_q[g].size() != 0) cur = exp_q[g].pop_front();
                    in_frame = 1'b1;
                    cyc      = 0;
                end
            end
        end
    end

    // Queue a byte and its hand-computed frame (par is ignored for instance 0).
    task automatic push(input int k, input logic [7:0] d, input logic par);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (k != 0) f[9] = par;
        fifo_q[k].push_back(d);
        exp_q[k].push_back(f);
    endtask

    function automatic bit all_idle();
        return !g_ch[0].in_frame && !g_ch[1].in_frame && !g_ch[2].in_frame
            && fifo_q[0].size() == 0 && fifo_q[1].size() == 0 && fifo_q[2].size() == 0
            && exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0;
    endfunction

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clock);
            #2;
            ok = all_idle();
        end
        check({name, " idle wait"}, ok, 1);
    endtask

    // Returns in the pop cycle of instance 0 (at negedge + 2).
    task automatic wait_pop0(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            #2;
            ok = g_ch[0].rd;
        end
        check({name, " pop wait"}, ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p0;
        bit  ok;
        reset_n = 1'b1;
        tx_en   = 3'b111;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        check("reset tx", g_ch[0].tx, 1);
        check("reset busy", g_ch[0].busy, 0);
        check("reset read_enable", g_ch[0].rd, 0);
        check("reset frame_done", g_ch[0].done, 0);
        @(posedge clock);
        #2 reset_n = 1'b1;

        // Single frame, no parity.
        @(negedge clock);
        push(0, 8'hA5, 1'b0);
        wait_idle("t1");

        // Parity variants: even on 0x07 -> 1, even on 0x00 -> 0, odd on 0x07 -> 0, odd on 0x00 -> 1.
        @(negedge clock);
        push(1, 8'h07, 1'b1);
        push(1, 8'h00, 1'b0);
        push(2, 8'h07, 1'b0);
        push(2, 8'h00, 1'b1);
        wait_idle("t2");

        // Back-to-back bytes.
        p0 = g_ch[0].pops;
        @(negedge clock);
        push(0, 8'h3C, 1'b0);
        push(0, 8'hC3, 1'b0);
        wait_idle("t3");
        check("t3 pop count", g_ch[0].pops - p0, 2);

        // Long empty period, then one byte.
        p0 = g_ch[0].pops;
        repeat (100) @(negedge clock);
        #2;
        check("t4 no pop while empty", g_ch[0].pops - p0, 0);
        @(negedge clock);
        push(0, 8'h55, 1'b0);
        wait_idle("t4");

        // tx_enable drops during data bit 3 with a second byte pending.
        @(negedge clock);
        push(0, 8'h96, 1'b0);
        push(0, 8'h69, 1'b0);
        wait_pop0("t5");
        repeat (18) @(negedge clock);
        tx_en[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            #2;
            ok = !g_ch[0].in_frame;
        end
        check("t5 frame end wait", ok, 1);
        p0 = g_ch[0].pops;
        repeat (20) @(negedge clock);
        #2;
        check("t5 no pop while disabled", g_ch[0].pops - p0, 0);
        check("t5 byte still queued", fifo_q[0].size(), 1);
        @(negedge clock);
        tx_en[0] = 1'b1;
        wait_idle("t5");

        // Asynchronous reset mid-data; partial byte discarded.
        @(negedge clock);
        push(0, 8'h5A, 1'b0);
        push(0, 8'hF0, 1'b0);
        wait_pop0("t6");
        repeat (20) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("t6 async tx", g_ch[0].tx, 1);
        check("t6 async busy", g_ch[0].busy, 0);
        check("t6 async read_enable", g_ch[0].rd, 0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        wait_idle("t6");

        check("final pops i0", g_ch[0].pops, 8);
        check("final pops i1", g_ch[1].pops, 2);
        check("final pops i2", g_ch[2].pops, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
